// File: rtl/wconv_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wconv_fifo
// Description : Single-clock width-converting FIFO. Stores WRITE_WIDTH-bit
//               push words and delivers each as RATIO sub-words of
//               WRITE_WIDTH/RATIO bits, most-significant slice first.
//               Provides full / almost-full / empty flags, entry and sub-word
//               counts, and registered overflow / underflow pulses.
//               Define WCONV_FIFO_FWFT_EN for first-word fall-through output;
//               otherwise oPopData is registered with one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module wconv_fifo #(
   parameter int WRITE_WIDTH        = 18,
   parameter int RATIO              = 2,
   parameter int DEPTH_LOG2         = 6,
   parameter int ALMOST_FULL_THRESH = 60,
   localparam int READ_WIDTH        = WRITE_WIDTH / RATIO,
   localparam int RL                = $clog2(RATIO)
) (
   input  logic                      iClock,
   input  logic                      iReset,
   input  logic [WRITE_WIDTH-1:0]    iPushData,
   input  logic                      iPushEnable,
   output logic                      oIsFull,
   output logic                      oIsAlmostFull,
   output logic                      oOverflow,
   output logic [READ_WIDTH-1:0]     oPopData,
   input  logic                      iPopEnable,
   output logic                      oIsEmpty,
   output logic                      oUnderflow,
   output logic [DEPTH_LOG2:0]       oDataCount,
   output logic [DEPTH_LOG2+RL:0]    oReadCount
);

   // Sub-index width is at least one bit so RATIO=1 still has a legal vector.
   localparam int SW  = (RL > 0) ? RL : 1;
   localparam int PW  = DEPTH_LOG2 + 1;
   localparam int RCW = DEPTH_LOG2 + RL + 1;

   localparam logic [PW-1:0] c_depth    = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [PW-1:0] c_afThresh = PW'(ALMOST_FULL_THRESH);
   localparam logic [SW-1:0] c_lastSub  = SW'(RATIO - 1);

   logic [WRITE_WIDTH-1:0] r_mem [2**DEPTH_LOG2];
   logic [PW-1:0]          r_wPtr;
   logic [PW-1:0]          r_rPtr;
   logic [SW-1:0]          r_sIdx;
   logic                   r_overflow;
   logic                   r_underflow;

   logic [PW-1:0]          w_count;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_pushOk;
   logic                   w_popOk;
   logic                   w_lastSub;
   logic [WRITE_WIDTH-1:0] w_headWord;
   logic [READ_WIDTH-1:0]  w_headSub;

   // Flags and counts come straight from the registered pointers.
   assign w_count   = r_wPtr - r_rPtr;
   assign w_full    = (w_count == c_depth);
   assign w_empty   = (r_wPtr == r_rPtr);
   assign w_pushOk  = iPushEnable & ~w_full;
   assign w_popOk   = iPopEnable & ~w_empty;
   assign w_lastSub = (r_sIdx == c_lastSub);

   // Storage write; contents are deliberately left unreset.
   always_ff @(posedge iClock) begin
      if (w_pushOk) begin
         r_mem[r_wPtr[DEPTH_LOG2-1:0]] <= iPushData;
      end
   end

   // Pointer advance and registered reject pulses.
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         r_wPtr      <= '0;
         r_rPtr      <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_pushOk) begin
            r_wPtr <= r_wPtr + PW'(1);
         end
         if (w_popOk && w_lastSub) begin
            r_rPtr <= r_rPtr + PW'(1);
         end
         r_overflow  <= iPushEnable & w_full;
         r_underflow <= iPopEnable & w_empty;
      end
   end

   generate
      if (RATIO > 1) begin : g_subIdx
         // Sub-word index walks 0..RATIO-1 within the head entry.
         always_ff @(posedge iClock or negedge iReset) begin
            if (!iReset) begin
               r_sIdx <= '0;
            end else if (w_popOk) begin
               r_sIdx <= w_lastSub ? '0 : r_sIdx + SW'(1);
            end
         end
      end else begin : g_noSubIdx
         assign r_sIdx = '0;
      end
   endgenerate

   assign w_headWord = r_mem[r_rPtr[DEPTH_LOG2-1:0]];

   // Select the head sub-word: index 0 maps to the most-significant slice.
   always_comb begin
      w_headSub = w_headWord[READ_WIDTH-1:0];
      for (int k = 0; k < RATIO; k++) begin
         if (r_sIdx == SW'(k)) begin
            w_headSub = w_headWord[(RATIO-1-k)*READ_WIDTH +: READ_WIDTH];
         end
      end
   end

`ifdef WCONV_FIFO_FWFT_EN
   // Head sub-word is presented directly; forced to zero while empty.
   assign oPopData = w_empty ? '0 : w_headSub;
`else
   logic [READ_WIDTH-1:0] r_popData;

   // Registered read data, loaded only on an accepted pop.
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         r_popData <= '0;
      end else if (w_popOk) begin
         r_popData <= w_headSub;
      end
   end

   assign oPopData = r_popData;
`endif

   assign oIsFull       = w_full;
   assign oIsEmpty      = w_empty;
   assign oIsAlmostFull = (w_count >= c_afThresh);
   assign oOverflow     = r_overflow;
   assign oUnderflow    = r_underflow;
   assign oDataCount    = w_count;
   assign oReadCount    = (RCW'(w_count) << RL) - RCW'(r_sIdx);

endmodule
`default_nettype wire

// File: tb/tb_wconv_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_wconv_fifo
// Description : Self-checking bench for wconv_fifo. A sub-word queue model
//               predicts every output each cycle; literal checks pin the
//               model on the key scenarios. Honours WCONV_FIFO_FWFT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wconv_fifo;

   localparam int WW    = 18;
   localparam int R     = 2;
   localparam int DL    = 6;
   localparam int AFT   = 60;
   localparam int RW    = WW / R;
   localparam int DEPTH = 1 << DL;

   logic          iClock      = 1'b0;
   logic          iReset      = 1'b0;
   logic [WW-1:0] iPushData   = '0;
   logic          iPushEnable = 1'b0;
   logic          iPopEnable  = 1'b0;
   logic          oIsFull;
   logic          oIsAlmostFull;
   logic          oOverflow;
   logic [RW-1:0] oPopData;
   logic          oIsEmpty;
   logic          oUnderflow;
   logic [DL:0]   oDataCount;
   logic [DL+1:0] oReadCount;

   wconv_fifo #(
      .WRITE_WIDTH        (WW),
      .RATIO              (R),
      .DEPTH_LOG2         (DL),
      .ALMOST_FULL_THRESH (AFT)
   ) dut (
      .iClock        (iClock),
      .iReset        (iReset),
      .iPushData     (iPushData),
      .iPushEnable   (iPushEnable),
      .oIsFull       (oIsFull),
      .oIsAlmostFull (oIsAlmostFull),
      .oOverflow     (oOverflow),
      .oPopData      (oPopData),
      .iPopEnable    (iPopEnable),
      .oIsEmpty      (oIsEmpty),
      .oUnderflow    (oUnderflow),
      .oDataCount    (oDataCount),
      .oReadCount    (oReadCount)
   );

   always #5 iClock = ~iClock;

   int compared   = 0;
   int mismatched = 0;

   // Model: queue of unread sub-words in delivery order.
   logic [RW-1:0] q[$];
   logic [RW-1:0] lastPop = '0;
   logic          expOv   = 1'b0;
   logic          expUf   = 1'b0;

   function automatic int entries();
      return (q.size() + R - 1) / R;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic check();
      cmp("empty",      {31'b0, oIsEmpty},      {31'b0, q.size() == 0});
      cmp("full",       {31'b0, oIsFull},       {31'b0, entries() == DEPTH});
      cmp("almostFull", {31'b0, oIsAlmostFull}, {31'b0, entries() >= AFT});
      cmp("overflow",   {31'b0, oOverflow},     {31'b0, expOv});
      cmp("underflow",  {31'b0, oUnderflow},    {31'b0, expUf});
      cmp("dataCount",  32'(oDataCount),        32'(entries()));
      cmp("readCount",  32'(oReadCount),        32'(q.size()));
`ifdef WCONV_FIFO_FWFT_EN
      if (q.size() != 0) cmp("popData", 32'(oPopData), 32'(q[0]));
`else
      cmp("popData", 32'(oPopData), 32'(lastPop));
`endif
   endtask

   // One clock: drive, let the edge happen, advance the model from the
   // pre-edge state, then check every output on the falling edge.
   task automatic step(input logic push, input logic [WW-1:0] d, input logic pop);
      int  preN;
      logic preFull, preEmpty;
      iPushEnable = push;
      iPushData   = d;
      iPopEnable  = pop;
      @(posedge iClock);
      preN     = q.size();
      preFull  = (((preN + R - 1) / R) == DEPTH);
      preEmpty = (preN == 0);
      expOv    = push && preFull;
      expUf    = pop && preEmpty;
      if (pop && !preEmpty) lastPop = q.pop_front();
      if (push && !preFull) begin
         for (int k = 0; k < R; k++) q.push_back(d[(R-1-k)*RW +: RW]);
      end
      @(negedge iClock);
      check();
   endtask

   task automatic drain();
      int guard = 0;
      while (q.size() != 0 && guard < 1000) begin
         step(1'b0, '0, 1'b1);
         guard++;
      end
      cmp("drainDone", 32'(q.size()), 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge iClock);
      check();
      cmp("lit_resetEmpty", {31'b0, oIsEmpty}, 32'd1);
      iReset = 1'b1;

      // Single word split into two sub-words
      step(1'b1, 18'h3FE01, 1'b0);
      cmp("lit_rc2", 32'(oReadCount), 32'd2);
      cmp("lit_dc1", 32'(oDataCount), 32'd1);
`ifdef WCONV_FIFO_FWFT_EN
      cmp("lit_head0", 32'(oPopData), 32'h1FF);
`endif
      step(1'b0, '0, 1'b1);
      cmp("lit_rc1", 32'(oReadCount), 32'd1);
      cmp("lit_dc1b", 32'(oDataCount), 32'd1);
`ifdef WCONV_FIFO_FWFT_EN
      cmp("lit_head1", 32'(oPopData), 32'h001);
`else
      cmp("lit_pop0", 32'(oPopData), 32'h1FF);
`endif
      step(1'b0, '0, 1'b1);
      cmp("lit_rc0", 32'(oReadCount), 32'd0);
      cmp("lit_dc0", 32'(oDataCount), 32'd0);
`ifndef WCONV_FIFO_FWFT_EN
      cmp("lit_pop1", 32'(oPopData), 32'h001);
`endif

      // Fill to full, then one rejected push
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, WW'(i * 1031 + 5), 1'b0);
         if (i == AFT - 2) cmp("lit_afBelow", {31'b0, oIsAlmostFull}, 32'd0);
         if (i == AFT - 1) cmp("lit_afAt", {31'b0, oIsAlmostFull}, 32'd1);
      end
      cmp("lit_full", {31'b0, oIsFull}, 32'd1);
      step(1'b1, 18'h3FFFF, 1'b0);
      cmp("lit_ovf", {31'b0, oOverflow}, 32'd1);
      cmp("lit_dc64", 32'(oDataCount), 32'd64);

      // Pop first sub-word, then push+pop the second on a full FIFO
      step(1'b0, '0, 1'b1);
      step(1'b1, 18'h12345, 1'b1);
      cmp("lit_ovf2", {31'b0, oOverflow}, 32'd1);
      cmp("lit_notFull", {31'b0, oIsFull}, 32'd0);
      cmp("lit_dc63", 32'(oDataCount), 32'd63);
      drain();

      // Pop on empty with simultaneous push
      step(1'b1, 18'h00155, 1'b1);
      cmp("lit_udf", {31'b0, oUnderflow}, 32'd1);
      cmp("lit_notEmpty", {31'b0, oIsEmpty}, 32'd0);
      step(1'b0, '0, 1'b1);
`ifndef WCONV_FIFO_FWFT_EN
      cmp("lit_pop155a", 32'(oPopData), 32'h000);
`else
      cmp("lit_head155", 32'(oPopData), 32'h155);
`endif
      step(1'b0, '0, 1'b1);
`ifndef WCONV_FIFO_FWFT_EN
      cmp("lit_pop155b", 32'(oPopData), 32'h155);
`endif

      // Continuous stream of 200 words across several pointer wraps
      for (int i = 0; i < 400; i++) begin
         step((i % 2) == 0, WW'((i / 2) * 2654435 + 17), i > 0);
      end
      drain();

      // Asynchronous reset with 10 entries queued
      for (int i = 0; i < 10; i++) step(1'b1, WW'(i + 100), 1'b0);
      iPushEnable = 1'b0;
      iPopEnable  = 1'b0;
      #2 iReset = 1'b0;
      #1;
      q.delete();
      lastPop = '0;
      expOv   = 1'b0;
      expUf   = 1'b0;
      check();
      cmp("lit_rstEmpty", {31'b0, oIsEmpty}, 32'd1);
      cmp("lit_rstRc", 32'(oReadCount), 32'd0);
      @(negedge iClock);
      check();
      iReset = 1'b1;
      step(1'b1, 18'h2AB3C, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
`ifndef WCONV_FIFO_FWFT_EN
      cmp("lit_rtLow", 32'(oPopData), 32'h13C);
`endif
      cmp("lit_rtEmpty", {31'b0, oIsEmpty}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
